// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - dual-write register file with bypass, optional zero R0 and clear sweep
module register_file_mp #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 2,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] waddr_a,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] waddr_b,
  input  logic [DATA_W-1:0] wdata_b,
  input  logic [ADDR_W-1:0] raddr_s,
  output logic [DATA_W-1:0] rdata_s,
  input  logic [ADDR_W-1:0] raddr_d,
  output logic [DATA_W-1:0] rdata_d,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              acc_a;
  logic              acc_b;

  // External writes are frozen for the whole sweep; on an address clash port B is dropped.
  always_comb begin
    acc_a = we_a && (state != SWEEP) && !((ZERO_R0 != 0) && (waddr_a == '0));
    acc_b = we_b && (state != SWEEP) && !((ZERO_R0 != 0) && (waddr_b == '0))
            && !(we_a && (waddr_a == waddr_b));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clr_req) state_next = SWEEP;
      SWEEP:   if (ptr == LAST_PTR) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    clr_busy = (state == SWEEP);
    clr_done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (state == IDLE && clr_req) begin
      ptr <= '0;
    end else if (state == SWEEP) begin
      ptr <= ptr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (state == SWEEP) begin
      regs[ptr] <= '0;
    end else begin
      if (acc_a) regs[waddr_a] <= wdata_a;
      if (acc_b) regs[waddr_b] <= wdata_b;
    end
  end

  // Port A is applied last so it wins the bypass when both ports hit the read address.
  always_comb begin
    rdata_s = regs[raddr_s];
    if (BYPASS != 0) begin
      if (acc_b && (waddr_b == raddr_s)) rdata_s = wdata_b;
      if (acc_a && (waddr_a == raddr_s)) rdata_s = wdata_a;
    end
    if ((ZERO_R0 != 0) && (raddr_s == '0)) rdata_s = '0;
  end

  always_comb begin
    rdata_d = regs[raddr_d];
    if (BYPASS != 0) begin
      if (acc_b && (waddr_b == raddr_d)) rdata_d = wdata_b;
      if (acc_a && (waddr_a == raddr_d)) rdata_d = wdata_a;
    end
    if ((ZERO_R0 != 0) && (raddr_d == '0)) rdata_d = '0;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// tb/tb_register_file_mp.sv - directed scoreboard bench for register_file_mp
module tb_register_file_mp;

  logic       clk;
  logic       rst;
  logic       we_a, we_b, clr_req;
  logic [1:0] waddr_a, waddr_b, raddr_s, raddr_d;
  logic [7:0] wdata_a, wdata_b;
  logic [7:0] rdata_s0, rdata_d0, rdata_s1, rdata_d1, rdata_s2, rdata_d2;
  logic       clr_busy0, clr_done0, clr_busy1, clr_done1, clr_busy2, clr_done2;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } item_t;

  item_t sb[$];
  int    checks = 0;
  int    errors = 0;
  int    busy_cnt;
  int    done_cnt;

  // u0: bypass on; u1: bypass off; u2: hardwired-zero R0
  register_file_mp #(.DATA_W(8), .ADDR_W(2), .ZERO_R0(0), .BYPASS(1)) u0 (
    .clk(clk), .rst(rst),
    .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
    .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
    .raddr_s(raddr_s), .rdata_s(rdata_s0), .raddr_d(raddr_d), .rdata_d(rdata_d0),
    .clr_req(clr_req), .clr_busy(clr_busy0), .clr_done(clr_done0)
  );

  register_file_mp #(.DATA_W(8), .ADDR_W(2), .ZERO_R0(0), .BYPASS(0)) u1 (
    .clk(clk), .rst(rst),
    .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
    .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
    .raddr_s(raddr_s), .rdata_s(rdata_s1), .raddr_d(raddr_d), .rdata_d(rdata_d1),
    .clr_req(clr_req), .clr_busy(clr_busy1), .clr_done(clr_done1)
  );

  register_file_mp #(.DATA_W(8), .ADDR_W(2), .ZERO_R0(1), .BYPASS(1)) u2 (
    .clk(clk), .rst(rst),
    .we_a(we_a), .waddr_a(waddr_a), .wdata_a(wdata_a),
    .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
    .raddr_s(raddr_s), .rdata_s(rdata_s2), .raddr_d(raddr_d), .rdata_d(rdata_d2),
    .clr_req(clr_req), .clr_busy(clr_busy2), .clr_done(clr_done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic push(input string tag, input logic [7:0] exp);
    item_t it;
    it.tag = tag;
    it.exp = exp;
    sb.push_back(it);
  endtask

  task automatic check(input logic [7:0] obs);
    item_t it;
    it = sb.pop_front();
    checks++;
    assert (obs === it.exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", it.tag, obs, it.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst = 1'b1; we_a = 0; we_b = 0; clr_req = 0;
    waddr_a = 0; waddr_b = 0; wdata_a = 0; wdata_b = 0; raddr_s = 0; raddr_d = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    settle();
    push("reset_rdata_s", 8'h00); check(rdata_s0);
    push("reset_busy", 8'h00);    check({7'b0, clr_busy0});
    push("reset_done", 8'h00);    check({7'b0, clr_done0});

    // dual write to distinct addresses
    we_a = 1; waddr_a = 1; wdata_a = 8'h3C;
    we_b = 1; waddr_b = 2; wdata_b = 8'hA5;
    raddr_s = 1; raddr_d = 2;
    settle();
    push("dual_bypass_s", 8'h3C);   check(rdata_s0);
    push("dual_nobypass_s", 8'h00); check(rdata_s1);
    tick(); we_a = 0; we_b = 0;
    settle();
    push("dual_r1", 8'h3C); check(rdata_s1);
    push("dual_r2", 8'hA5); check(rdata_d1);
    push("dual_r2_byp", 8'hA5); check(rdata_d0);

    // same-address collision: port A wins
    we_a = 1; waddr_a = 3; wdata_a = 8'h11;
    we_b = 1; waddr_b = 3; wdata_b = 8'h22;
    raddr_s = 3;
    settle();
    push("clash_bypass", 8'h11); check(rdata_s0);
    tick(); we_a = 0; we_b = 0;
    settle();
    push("clash_stored", 8'h11); check(rdata_s1);

    // bypass versus stored-only read
    we_b = 1; waddr_b = 2; wdata_b = 8'h5A; raddr_s = 2;
    settle();
    push("byp_same_cycle", 8'h5A); check(rdata_s0);
    push("nobyp_old", 8'hA5);      check(rdata_s1);
    tick(); we_b = 0;
    settle();
    push("nobyp_after_edge", 8'h5A); check(rdata_s1);

    // hardwired zero R0
    we_a = 1; waddr_a = 0; wdata_a = 8'hFF; raddr_s = 0;
    settle();
    push("zr0_same_cycle", 8'h00); check(rdata_s2);
    push("r0_bypass", 8'hFF);      check(rdata_s0);
    tick(); we_a = 0;
    settle();
    push("zr0_next_cycle", 8'h00); check(rdata_s2);
    push("r0_stored", 8'hFF);      check(rdata_s0);

    // asynchronous reset between edges
    raddr_s = 0; raddr_d = 2;
    rst = 1; #1;
    push("async_rst_s", 8'h00); check(rdata_s0);
    push("async_rst_d", 8'h00); check(rdata_d0);
    rst = 0;
    tick();

    // load R0..R3 = 1..4
    we_a = 1; waddr_a = 0; wdata_a = 8'h01; we_b = 1; waddr_b = 1; wdata_b = 8'h02;
    tick();
    waddr_a = 2; wdata_a = 8'h03; waddr_b = 3; wdata_b = 8'h04;
    tick(); we_a = 0; we_b = 0;

    clr_req = 1;
    tick(); clr_req = 0;
    busy_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      raddr_d = 2'(k);
      raddr_s = (k == 0) ? 2'd0 : 2'(k - 1);
      settle();
      if (clr_busy0) busy_cnt++;
      push("sweep_not_yet_cleared", 8'(k + 1)); check(rdata_d0);
      if (k > 0) begin
        push("sweep_cleared", 8'h00); check(rdata_s0);
      end
      if (k == 1) begin
        we_a = 1; waddr_a = 3; wdata_a = 8'h77; raddr_s = 3; #1;
        push("sweep_write_not_bypassed", 8'h04); check(rdata_s0);
      end
      if (k == 2) clr_req = 1;
      if (k == 3) clr_req = 0;
      tick(); we_a = 0;
    end
    settle();
    push("done_busy", 8'h00); check({7'b0, clr_busy0});
    push("done_pulse", 8'h01); check({7'b0, clr_done0});
    raddr_s = 3; raddr_d = 0; #1;
    push("done_r3", 8'h00); check(rdata_s0);
    push("done_r0", 8'h00); check(rdata_d0);
    // writes are accepted during DONE
    we_a = 1; waddr_a = 1; wdata_a = 8'h42;
    tick(); we_a = 0;
    settle();
    push("after_done_pulse", 8'h00); check({7'b0, clr_done0});
    push("no_second_sweep", 8'h00);  check({7'b0, clr_busy0});
    push("busy_cycles", 8'd4);       check(8'(busy_cnt));
    raddr_s = 1; #1;
    push("done_cycle_write", 8'h42); check(rdata_s0);

    // reset in the middle of a sweep
    we_b = 1; waddr_b = 3; wdata_b = 8'h33;
    tick(); we_b = 0;
    clr_req = 1;
    tick(); clr_req = 0;
    tick();
    tick();
    settle();
    push("mid_sweep_busy", 8'h01); check({7'b0, clr_busy0});
    raddr_s = 3; raddr_d = 1; #1;
    push("mid_sweep_r3", 8'h33); check(rdata_s0);
    rst = 1; #1;
    push("rst_busy_drop", 8'h00); check({7'b0, clr_busy0});
    push("rst_r3", 8'h00);        check(rdata_s0);
    push("rst_r1", 8'h00);        check(rdata_d0);
    tick(); rst = 0;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      settle();
      if (clr_done0) done_cnt++;
      tick();
    end
    push("rst_no_done", 8'h00); check(8'(done_cnt));

    clr_req = 1;
    tick(); clr_req = 0;
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      settle();
      if (clr_busy0) busy_cnt++;
      if (clr_done0) done_cnt++;
      tick();
    end
    push("resweep_busy_cycles", 8'd4); check(8'(busy_cnt));
    push("resweep_done_pulses", 8'd1); check(8'(done_cnt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
